// File: rtl/dm_pkg.sv
// dm_pkg: shared types and helpers for the byte-addressable MEM-stage data
// memory (dm_ext) and its load lane extender (dm_lane_ext).
//   dm_op_e    : 4-bit operation code, bit 3 set for stores
//   dm_state_e : clear-sweep FSM states
//   DM_WORD_W  : memory word width
package dm_pkg;

  localparam int DM_WORD_W = 32;

  typedef enum logic [3:0] {
    DM_NONE = 4'd0,
    DM_LW   = 4'd1,
    DM_LH   = 4'd2,
    DM_LHU  = 4'd3,
    DM_LB   = 4'd4,
    DM_LBU  = 4'd5,
    DM_SW   = 4'd8,
    DM_SH   = 4'd9,
    DM_SB   = 4'd10
  } dm_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dm_state_e;

  function automatic logic dm_is_load(input dm_op_e op);
    return (op == DM_LW) || (op == DM_LH) || (op == DM_LHU) ||
           (op == DM_LB) || (op == DM_LBU);
  endfunction

  // Unused encodings with bit 3 set are not stores; only the three legal ones.
  function automatic logic dm_is_store(input dm_op_e op);
    return (op == DM_SW) || (op == DM_SH) || (op == DM_SB);
  endfunction

  // Natural alignment: words on 4-byte boundaries, halfwords on 2-byte ones.
  function automatic logic dm_misaligned(input dm_op_e op, input logic [1:0] lsb);
    case (op)
      DM_LW, DM_SW:          return lsb != 2'b00;
      DM_LH, DM_LHU, DM_SH:  return lsb[0];
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// dm_lane_ext: picks the addressed byte/halfword out of a little-endian word
// and sign- or zero-extends it according to the load opcode.
//   op       : load opcode (non-load opcodes give 0)
//   byte_off : byte address bits [1:0]
//   word     : full memory word at the word index
//   data     : extended load result
module dm_lane_ext
  import dm_pkg::*;
(
  input  dm_op_e               op,
  input  logic [1:0]           byte_off,
  input  logic [DM_WORD_W-1:0] word,
  output logic [DM_WORD_W-1:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  assign half = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps a latch from being inferred.
    byte_sel = word[7:0];
    case (byte_off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  always_comb begin
    data = '0;
    case (op)
      DM_LW:   data = word;
      DM_LH:   data = {{16{half[15]}}, half};
      DM_LHU:  data = {16'h0000, half};
      DM_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      DM_LBU:  data = {24'h000000, byte_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_ext.sv
// dm_ext: byte-addressable data memory for the pipelined MIPS MEM stage.
// Word/halfword/byte loads (sign/zero extended) and stores via per-lane byte
// enables; flags misaligned and out-of-range accesses; optional clear sweep.
//   clk      : clock, all state changes on the rising edge
//   res      : asynchronous active-low reset
//   dm_op    : operation code (dm_op_e encoding)
//   dm_addr  : byte address; word index = dm_addr[ADDR_W-1:2]
//   dm_wdata : store data (low byte/halfword used for SB/SH)
//   clr_req  : single-cycle request to re-clear the whole memory
//   dm_rdata : extended load data, combinational
//   dm_busy  : clear sweep running, MEM must stall
//   dm_exc   : current access misaligned or out of range, combinational
// Build option: define DM_CLEAR_SWEEP_EN to enable the clear sweep FSM. Without
// it there is no FSM, dm_busy is 0, clr_req is ignored and contents after
// reset are undefined.
module dm_ext
  import dm_pkg::*;
#(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [3:0]           dm_op,
  input  logic [ADDR_W-1:0]    dm_addr,
  input  logic [DM_WORD_W-1:0] dm_wdata,
  input  logic                 clr_req,
  output logic [DM_WORD_W-1:0] dm_rdata,
  output logic                 dm_busy,
  output logic                 dm_exc
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // When the index space is exactly DEPTH words nothing can be out of range.
  localparam bit HAS_OOR = ((2 ** IDX_W) > DEPTH);
  localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_IDX  = MEM_AW'(DEPTH - 1);

  logic [DM_WORD_W-1:0] mem [DEPTH];

  dm_op_e               op;
  logic [IDX_W-1:0]     word_idx;
  logic [MEM_AW-1:0]    mem_idx;
  logic                 is_load;
  logic                 is_store;
  logic                 out_of_range;
  logic                 clearing;
  logic                 store_en;
  logic [3:0]           byte_en;
  logic [DM_WORD_W-1:0] wr_lanes;
  logic [DM_WORD_W-1:0] ext_data;

  assign op       = dm_op_e'(dm_op);
  assign word_idx = dm_addr[ADDR_W-1:2];
  // Only used when in range, so dropping the upper index bits is safe.
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign is_load  = dm_is_load(op);
  assign is_store = dm_is_store(op);

  assign out_of_range = HAS_OOR && (word_idx >= DEPTH_IDX);
  assign dm_exc       = (is_load || is_store) &&
                        (dm_misaligned(op, dm_addr[1:0]) || out_of_range);

  // --------------------------------------------------------------------------
  // Clear sweep FSM
  // --------------------------------------------------------------------------
`ifdef DM_CLEAR_SWEEP_EN
  dm_state_e         state;
  logic [MEM_AW-1:0] clr_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= CLEAR;
      clr_idx <= '0;
      dm_busy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            dm_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= IDLE;
            dm_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          dm_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clearing = (state == CLEAR);
`else
  logic unused_clr_req;

  assign unused_clr_req = clr_req;
  assign clearing       = 1'b0;
  assign dm_busy        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Store path: replicate the low lane(s) across the word, enable only the
  // addressed lanes.
  // --------------------------------------------------------------------------
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = dm_wdata;
    case (op)
      DM_SW: byte_en = 4'b1111;
      DM_SH: begin
        byte_en  = dm_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{dm_wdata[15:0]}};
      end
      DM_SB: begin
        byte_en  = 4'b0001 << dm_addr[1:0];
        wr_lanes = {4{dm_wdata[7:0]}};
      end
      default: byte_en = 4'b0000;
    endcase
  end

  assign store_en = is_store && !dm_exc && !clearing;

  // NOTE: the memory array has no reset; resetting thousands of words would
  // prevent RAM inference, and the clear sweep covers initialisation instead.
  always_ff @(posedge clk) begin
`ifdef DM_CLEAR_SWEEP_EN
    if (clearing) begin
      mem[clr_idx] <= '0;
    end else
`endif
    if (store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[mem_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load path
  // --------------------------------------------------------------------------
  dm_lane_ext u_lane_ext (
    .op       (op),
    .byte_off (dm_addr[1:0]),
    .word     (mem[mem_idx]),
    .data     (ext_data)
  );

  assign dm_rdata = (is_load && !dm_exc && !clearing) ? ext_data : '0;

endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: scoreboard bench for dm_ext. The driver issues one operation per
// cycle, predicts the response from a byte-array model of the memory and
// pushes it; a monitor pops and compares on each falling edge.
module tb_dm_ext;
  import dm_pkg::*;

  localparam int DEPTH  = 3072;
  localparam int ADDR_W = 16;
`ifdef DM_CLEAR_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [3:0]  dm_op = 4'd0;
  logic [15:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        clr_req = 1'b0;
  logic [31:0] dm_rdata;
  logic        dm_busy;
  logic        dm_exc;

  dm_ext #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .res      (res),
    .dm_op    (dm_op),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .clr_req  (clr_req),
    .dm_rdata (dm_rdata),
    .dm_busy  (dm_busy),
    .dm_exc   (dm_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        exc;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain byte array plus remaining sweep cycles.
  byte unsigned mem_m [DEPTH*4];
  int           sweep_left = 0;

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        bad = 1'b0;
        if (dm_rdata !== e.rd) begin
          $display("FAIL %s: rdata=%h expected %h", e.name, dm_rdata, e.rd);
          bad = 1'b1;
        end
        if (dm_exc !== e.exc) begin
          $display("FAIL %s: exc=%b expected %b", e.name, dm_exc, e.exc);
          bad = 1'b1;
        end
        if (dm_busy !== e.busy) begin
          $display("FAIL %s: busy=%b expected %b", e.name, dm_busy, e.busy);
          bad = 1'b1;
        end
        if (bad) errors++;
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd8:       return 4;
      4'd2, 4'd3, 4'd9: return 2;
      4'd4, 4'd5, 4'd10: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
  endfunction

  // Drive one operation for one cycle (entered and left at posedge+1).
  task automatic issue(input logic [3:0] op, input int addr, input logic [31:0] wd,
                       input bit req, input string name);
    exp_t        e;
    int          sz;
    bit          exc;
    bit          busy;
    logic [31:0] v;
    sz   = op_size(op);
    exc  = (sz > 0) && (((addr % sz) != 0) || ((addr / 4) >= DEPTH));
    busy = (sweep_left > 0);
    v    = 32'h0;
    if (sz > 0 && !op_is_store(op) && !exc && !busy) begin
      for (int i = 0; i < sz; i++) v = v + (32'(mem_m[addr+i]) << (8*i));
      if (op == 4'd4 && v >= 32'd128)   v = v - 32'd256;
      if (op == 4'd2 && v >= 32'd32768) v = v - 32'd65536;
    end
    dm_op    = op;
    dm_addr  = addr[15:0];
    dm_wdata = wd;
    clr_req  = req;
    e.name = name; e.rd = v; e.exc = exc; e.busy = busy;
    sb_q.push_back(e);
    // Effect of the coming rising edge.
    if (busy) begin
      sweep_left--;
      if (sweep_left == 0) foreach (mem_m[i]) mem_m[i] = 8'h00;
    end else begin
      if (op_is_store(op) && !exc)
        for (int i = 0; i < sz; i++) mem_m[addr+i] = 8'(wd >> (8*i));
      if (req && SWEEP) sweep_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges while probing a misaligned LW, then release.
  task automatic do_reset(input string name);
    exp_t e;
    res      = 1'b0;
    dm_op    = DM_LW;
    dm_addr  = 16'h0002;
    dm_wdata = '0;
    clr_req  = 1'b0;
    e.name = name; e.rd = 32'h0; e.exc = 1'b1; e.busy = SWEEP;
    sb_q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    res        = 1'b1;
    dm_op      = DM_NONE;
    sweep_left = SWEEP ? DEPTH : 0;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (sweep_left > 0) begin
      issue(DM_NONE, 0, 32'h0, 1'b0, $sformatf("%s_c%0d", name, n));
      n++;
    end
    issue(DM_NONE, 0, 32'h0, 1'b0, $sformatf("%s_done", name));
  endtask

  logic [3:0] ops_tbl [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

  // ---------------- stimulus ----------------
  initial begin
    do_reset("reset");

    if (SWEEP) begin
      for (int c = 0; c < 10; c++) begin
        if (c == 5) issue(DM_SW, 32'h0, 32'h12345678, 1'b0, "sw_during_sweep");
        else        issue(DM_NONE, 0, 32'h0, 1'b0, $sformatf("sweep_c%0d", c));
      end
      wait_sweep("sweep");
    end else begin
      for (int w = 0; w < DEPTH; w++) issue(DM_SW, w*4, 32'h0, 1'b0, "init_sw");
    end

    issue(DM_LW, 32'h0000, 32'h0, 1'b0, "lw_0000");
    issue(DM_LW, 32'h2FFC, 32'h0, 1'b0, "lw_2ffc");

    // byte/halfword merge
    issue(DM_SW,  32'h10, 32'h11223344, 1'b0, "sw_10");
    issue(DM_SB,  32'h11, 32'h000000AB, 1'b0, "sb_11");
    issue(DM_SH,  32'h12, 32'h0000BEEF, 1'b0, "sh_12");
    issue(DM_LW,  32'h10, 32'h0, 1'b0, "lw_10");
    issue(DM_LB,  32'h11, 32'h0, 1'b0, "lb_11");
    issue(DM_LBU, 32'h11, 32'h0, 1'b0, "lbu_11");
    issue(DM_LH,  32'h12, 32'h0, 1'b0, "lh_12");
    issue(DM_LHU, 32'h12, 32'h0, 1'b0, "lhu_12");
    issue(DM_LB,  32'h10, 32'h0, 1'b0, "lb_10");

    // misalignment
    issue(DM_SW, 32'h20, 32'hCAFEF00D, 1'b0, "sw_20");
    issue(DM_SW, 32'h22, 32'hDEADBEEF, 1'b0, "sw_22_mis");
    issue(DM_LW, 32'h20, 32'h0, 1'b0, "lw_20_kept");
    issue(DM_LH, 32'h21, 32'h0, 1'b0, "lh_21_mis");
    issue(DM_SH, 32'h23, 32'h00001111, 1'b0, "sh_23_mis");
    issue(DM_LW, 32'h20, 32'h0, 1'b0, "lw_20_kept2");

    // out of range
    issue(DM_SW, 32'h0, 32'h0BADF00D, 1'b0, "sw_0");
    issue(DM_LW, 32'h3000, 32'h0, 1'b0, "lw_3000_oor");
    issue(DM_SW, 32'h3000, 32'h77777777, 1'b0, "sw_3000_oor");
    issue(DM_LW, 32'h0, 32'h0, 1'b0, "lw_0_kept");
    issue(DM_LBU, 32'hFFFF, 32'h0, 1'b0, "lbu_ffff_oor");

    // re-clear
    issue(DM_SW, 32'h40, 32'h5, 1'b0, "sw_40");
    issue(DM_LW, 32'h40, 32'h0, 1'b0, "lw_40_pre");
    issue(DM_NONE, 0, 32'h0, 1'b1, "clr_req");
    issue(DM_SW, 32'h44, 32'h99, 1'b0, "sw_44_busy");
    issue(DM_NONE, 0, 32'h0, 1'b1, "clr_req_ignored");
    wait_sweep("reclear");
    issue(DM_LW, 32'h40, 32'h0, 1'b0, "lw_40_post");
    issue(DM_LW, 32'h44, 32'h0, 1'b0, "lw_44_post");

    // mid-sweep reset
    do_reset("reset2");
    for (int c = 0; c < 100; c++) issue(DM_NONE, 0, 32'h0, 1'b0, "pre_reset3");
    do_reset("reset3");
    wait_sweep("midreset");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      int         addr;
      int         sel;
      op  = ops_tbl[$urandom_range(8, 0)];
      sel = $urandom_range(9, 0);
      if (sel < 7)      addr = $urandom_range(31, 0) * 4 + $urandom_range(3, 0);
      else if (sel < 8) addr = $urandom_range(DEPTH-1, DEPTH-8) * 4 + $urandom_range(3, 0);
      else              addr = $urandom_range(65535, 0);
      issue(op, addr, $urandom, 1'b0, $sformatf("rnd%0d_op%0d_a%h", i, op, addr[15:0]));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_ext.md
# dm_ext

Parametrised byte-addressable data memory for the pipelined MIPS core's MEM stage, replacing the word-only data memory. Supports word, halfword and byte loads and stores with sign and zero extension. Flags misaligned and out-of-range accesses. Runs a hardware clear sweep after reset or on request, and raises a stall while the sweep is in progress.

## Interface
- `DEPTH`, default 3072: number of 32-bit words.
- `ADDR_W`, default 16: byte-address width; must satisfy 2^(ADDR_W-2) >= DEPTH.
- `clk` in 1: clock; all state changes on the rising edge.
- `res` in 1: asynchronous, active-low reset.
- `dm_op` in 4: operation code (`DM_NONE`, `DM_LW`, `DM_LH`, `DM_LHU`, `DM_LB`, `DM_LBU`, `DM_SW`, `DM_SH`, `DM_SB`).
- `dm_addr` in ADDR_W: byte address.
- `dm_wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `clr_req` in 1: single-cycle request to re-clear the whole memory.
- `dm_rdata` out 32: extended load data; combinational.
- `dm_busy` out 1: clear sweep in progress; the pipeline must stall MEM.
- `dm_exc` out 1: current access is misaligned or out of range; combinational.

## Operation
- Word index = `dm_addr[ADDR_W-1:2]`. Lanes are little-endian: byte k = bits 8k+7:8k, selected by `dm_addr[1:0]`. A halfword uses lane pair `dm_addr[1]`.
- Loads:
  - LB/LH sign-extend the selected byte or halfword to 32 bits.
  - LBU/LHU zero-extend it.
  - LW returns the full word.
  - DM_NONE and store ops give `dm_rdata` = 0.
- Stores write only the selected lanes through a per-lane byte enable. The other lanes keep their old value.
- Exception conditions:
  - Misaligned: LW/SW with `dm_addr[1:0]` != 0, or LH/LHU/SH with `dm_addr[0]` != 0.
  - Out of range: word index >= DEPTH.
  - Response: `dm_exc`=1, any store is suppressed, and `dm_rdata`=0.
- Clear FSM (states IDLE and CLEAR, with a word counter `clr_idx`):
  - CLEAR writes 0 to word `clr_idx` each cycle and increments it. At `clr_idx`=DEPTH-1 the FSM returns to IDLE on the next edge.
  - While in CLEAR: `dm_busy`=1, all external stores are ignored, and `dm_rdata`=0.
  - In IDLE, `clr_req`=1 moves the FSM to CLEAR with `clr_idx`=0 on the next edge. `clr_req` during CLEAR is ignored.

## Timing
- Reset values (`res`=0): state=CLEAR, `clr_idx`=0, `dm_busy`=1; `dm_rdata`=0 and `dm_exc` follow their combinational inputs. Without `DM_CLEAR_SWEEP_EN`: state=IDLE and `dm_busy`=0.
- Reset asserted mid-sweep restarts the sweep at word 0 once `res` is released.
- A full sweep takes exactly DEPTH cycles after reset release. `dm_busy` falls on edge DEPTH.
- Loads have zero latency: `dm_rdata` reflects the memory contents at the current address.
- Stores commit on the rising edge. A load of the same address in the same cycle returns the old data; the next cycle returns the new data.
- An IDLE cycle with a valid store and `clr_req`=1 together: the store commits, then the sweep starts.

## Configuration
- `DM_CLEAR_SWEEP_EN` defined: reset and `clr_req` start the sweep FSM as above.
- `DM_CLEAR_SWEEP_EN` undefined:
  - No FSM, no counter, `dm_busy` tied to 0, `clr_req` ignored.
  - Memory contents after reset are undefined (X in simulation).

## Structure
- Package `dm_pkg` holds:
  - the `dm_op_e` enum (4-bit encodings: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=8, SH=9, SB=10; bit 3 = store);
  - the `dm_state_e` enum {IDLE, CLEAR};
  - the `DM_WORD_W`=32 constant.
- One sub-module, `dm_lane_ext`: combinational lane select plus sign/zero extension for loads. The byte-enable generation stays in `dm_ext`.

## Test plan
- Sweep after reset: release `res`; `dm_busy` stays 1 for exactly 3072 cycles. Afterwards, LW at 0x0000 and LW at 0x2FFC both return 0x00000000.
- Byte/halfword merge: SW 0x11223344 @0x10, then SB 0xAB @0x11, then SH 0xBEEF @0x12. Then LW @0x10 -> 0xBEEFAB44, LB @0x11 -> 0xFFFFFFAB, LBU @0x11 -> 0x000000AB, LH @0x12 -> 0xFFFFBEEF.
- Misalignment: SW 0xDEADBEEF @0x22 -> `dm_exc`=1, and a subsequent LW @0x20 returns the prior value. LH @0x21 -> `dm_exc`=1, `dm_rdata`=0.
- Out of range: LW @0x3000 (word 3072) -> `dm_exc`=1, `dm_rdata`=0; SW there leaves word 0 unchanged.
- Re-clear: write 0x5 @0x40, pulse `clr_req` -> `dm_busy`=1 on the next cycle. A SW issued during busy is dropped. After 3072 cycles, LW @0x40 -> 0.
- Mid-sweep reset: assert `res`=0 at sweep cycle 100; after release, `dm_busy` lasts a full 3072 cycles.
